// File: rtl/morse_led_decoder.sv
`default_nettype none
// ============================================================================
// Module   : morse_led_decoder
// Purpose  : Reconstructs letters from a Morse-keyed LED line. The line is
//            synchronised, mark/space durations are measured in clock cycles
//            and classified against a 2-unit threshold, up to MAX_SYM
//            dot/dash symbols are collected, and one letter code (A=0..Z=25,
//            31 on error) is emitted with a single-cycle valid pulse.
// Ports    : clk        - system clock
//            rst        - asynchronous reset, active low
//            led        - keyed line, 1 = mark
//            char_valid - one-cycle pulse, new letter decoded
//            char_code  - letter index, 31 on error (holds between letters)
//            char_err   - unknown pattern or symbol overflow
//            busy       - a letter is being received
// Revision : 1.0 - initial release
// ============================================================================
module morse_led_decoder #(
  parameter int UNIT_CYCLES = 2,
  parameter int MAX_SYM     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       led,
  output logic       char_valid,
  output logic [4:0] char_code,
  output logic       char_err,
  output logic       busy
);

  localparam int TH      = 2 * UNIT_CYCLES;
  localparam int MAX_CNT = 8 * UNIT_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [CW-1:0] C_TH      = CW'(TH);
  localparam logic [CW-1:0] C_MAX_CNT = CW'(MAX_CNT);
  localparam logic [2:0]    C_SYM_MAX = 3'(MAX_SYM);
  localparam logic [4:0]    C_ERR     = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    EMIT  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_n;
  logic            led_m;
  logic            led_s;
  logic [CW-1:0]   count;
  logic [2:0]      sym_cnt;
  logic [4:0]      pattern;
  logic            ovf;
  logic            dash;
  logic            cnt_load;
  logic            cnt_inc;
  logic            push_sym;
  logic            clr_letter;
  logic            emit_load;
  logic [4:0]      lut_code;
  logic            lut_err;

  // A finished mark is a dash once it lasted TH cycles; a saturated count
  // still compares as a dash.
  assign dash = (count >= C_TH);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_n    = state;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    push_sym   = 1'b0;
    clr_letter = 1'b0;
    case (state)
      IDLE: begin
        if (led_s) begin
          state_n  = MARK;
          cnt_load = 1'b1;
        end
      end
      MARK: begin
        if (led_s) begin
          cnt_inc = 1'b1;
        end else begin
          push_sym = 1'b1;
          cnt_load = 1'b1;
          state_n  = SPACE;
        end
      end
      SPACE: begin
        if (led_s) begin
          state_n  = MARK;
          cnt_load = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          // This low sample brings the space to TH cycles: letter is over.
          if (count == C_TH - C_ONE) begin
            state_n = EMIT;
          end
        end
      end
      EMIT: begin
        clr_letter = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // EMIT is only ever entered from SPACE and lasts one cycle, so this fires
  // exactly once per letter and the result is in place during EMIT.
  assign emit_load = (state_n == EMIT);

  // --------------------------------------------------------------------------
  // Letter lookup keyed by {symbol count, pattern}; first symbol in the
  // highest used bit, 1 = dash.
  // --------------------------------------------------------------------------
  always_comb begin
    lut_code = C_ERR;
    lut_err  = 1'b1;
    if (!ovf) begin
      lut_err = 1'b0;
      case ({sym_cnt, pattern})
        {3'd2, 5'b00001}: lut_code = 5'd0;   // A .-
        {3'd4, 5'b01000}: lut_code = 5'd1;   // B -...
        {3'd4, 5'b01010}: lut_code = 5'd2;   // C -.-.
        {3'd3, 5'b00100}: lut_code = 5'd3;   // D -..
        {3'd1, 5'b00000}: lut_code = 5'd4;   // E .
        {3'd4, 5'b00010}: lut_code = 5'd5;   // F ..-.
        {3'd3, 5'b00110}: lut_code = 5'd6;   // G --.
        {3'd4, 5'b00000}: lut_code = 5'd7;   // H ....
        {3'd2, 5'b00000}: lut_code = 5'd8;   // I ..
        {3'd4, 5'b00111}: lut_code = 5'd9;   // J .---
        {3'd3, 5'b00101}: lut_code = 5'd10;  // K -.-
        {3'd4, 5'b00100}: lut_code = 5'd11;  // L .-..
        {3'd2, 5'b00011}: lut_code = 5'd12;  // M --
        {3'd2, 5'b00010}: lut_code = 5'd13;  // N -.
        {3'd3, 5'b00111}: lut_code = 5'd14;  // O ---
        {3'd4, 5'b00110}: lut_code = 5'd15;  // P .--.
        {3'd4, 5'b01101}: lut_code = 5'd16;  // Q --.-
        {3'd3, 5'b00010}: lut_code = 5'd17;  // R .-.
        {3'd3, 5'b00000}: lut_code = 5'd18;  // S ...
        {3'd1, 5'b00001}: lut_code = 5'd19;  // T -
        {3'd3, 5'b00001}: lut_code = 5'd20;  // U ..-
        {3'd4, 5'b00001}: lut_code = 5'd21;  // V ...-
        {3'd3, 5'b00011}: lut_code = 5'd22;  // W .--
        {3'd4, 5'b01001}: lut_code = 5'd23;  // X -..-
        {3'd4, 5'b01011}: lut_code = 5'd24;  // Y -.--
        {3'd4, 5'b01100}: lut_code = 5'd25;  // Z --..
        default: begin
          lut_code = C_ERR;
          lut_err  = 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Synchroniser, duration counter, symbol accumulator, output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_m     <= 1'b0;
      led_s     <= 1'b0;
      count     <= '0;
      sym_cnt   <= '0;
      pattern   <= '0;
      ovf       <= 1'b0;
      char_code <= '0;
      char_err  <= 1'b0;
    end else begin
      led_m <= led;
      led_s <= led_m;

      if (cnt_load) begin
        count <= C_ONE;
      end else if (cnt_inc && (count != C_MAX_CNT)) begin
        count <= count + C_ONE;
      end

      if (clr_letter) begin
        sym_cnt <= '0;
        pattern <= '0;
        ovf     <= 1'b0;
      end else if (push_sym) begin
        // Extra symbols beyond the limit only flag the letter as bad.
        if (sym_cnt == C_SYM_MAX) begin
          ovf <= 1'b1;
        end else begin
          pattern <= {pattern[3:0], dash};
          sym_cnt <= sym_cnt + 3'd1;
        end
      end

      if (emit_load) begin
        char_code <= lut_code;
        char_err  <= lut_err;
      end
    end
  end

  assign char_valid = (state == EMIT);
  assign busy       = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_morse_led_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_led_decoder
// Purpose  : Self-checking bench for morse_led_decoder. Stimulus is a list of
//            alternating mark/space run lengths; a run-length reference model
//            derives each expected letter, its code and the cycle of its valid
//            pulse, and these are compared with pulses captured from the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morse_led_decoder;

  localparam int UNIT = 2;
  localparam int TH   = 2 * UNIT;

  logic       clk = 1'b0;
  logic       rst;
  logic       led;
  logic       char_valid;
  logic [4:0] char_code;
  logic       char_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  morse_led_decoder #(.UNIT_CYCLES(UNIT), .MAX_SYM(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .led        (led),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_err   (char_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Cycle number = count of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse capture; idle_since counts busy-low samples since the last pulse.
  int obs_cyc[$];
  int obs_code[$];
  int obs_err[$];
  int obs_idle[$];
  int idle_since = 0;
  int busy_hi_total = 0;
  always @(negedge clk) begin
    if (busy === 1'b0) idle_since++;
    if (busy === 1'b1) busy_hi_total++;
    if (char_valid === 1'b1) begin
      obs_cyc.push_back(cyc);
      obs_code.push_back(int'(char_code));
      obs_err.push_back(int'(char_err));
      obs_idle.push_back(idle_since);
      idle_since = 0;
    end
  end

  string MORSE [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                        "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                        "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                        "-.--", "--.."};

  int exp_cyc[$];
  int exp_code[$];
  int exp_err[$];
  int q[$];
  int ob;

  function automatic int lookup(input string s);
    if (s.len() > 5) return 31;
    for (int i = 0; i < 26; i++) if (s == MORSE[i]) return i;
    return 31;
  endfunction

  // Drives alternating runs (mark first) and appends the model's expected
  // pulses. A letter closes after TH low cycles of led; the synchroniser puts
  // the TH-th low sample TH cycles after the first low sample, and the pulse
  // follows one cycle later.
  task automatic play(input int runs[$]);
    string sym;
    int    p;
    int    c;
    logic  lvl;
    sym = "";
    p   = 0;
    for (int i = 0; i < runs.size(); i++) begin
      lvl = (i % 2 == 0);
      for (int k = 0; k < runs[i]; k++) begin
        @(negedge clk);
        led = lvl;
        if (k == 0) p = cyc + 1;
      end
      if (lvl) begin
        if (runs[i] >= TH) sym = $sformatf("%s-", sym);
        else               sym = $sformatf("%s.", sym);
      end else if (runs[i] >= TH && sym.len() > 0) begin
        c = lookup(sym);
        exp_cyc.push_back(p + TH + 1);
        exp_code.push_back(c);
        exp_err.push_back((c == 31) ? 1 : 0);
        sym = "";
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    led = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", char_valid); end
    total++; if (char_code !== 5'd0) begin bad++; $display("FAIL reset_code: got %0d want 0", char_code); end
    total++; if (char_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", char_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b1;
  endtask

  task automatic test_idle();
    int bh;
    int np;
    @(negedge clk); rst = 1'b0; led = 1'b0;
    @(negedge clk); rst = 1'b1;
    bh = busy_hi_total;
    np = obs_cyc.size();
    repeat (100) @(negedge clk);
    total++; if (busy_hi_total - bh !== 0) begin bad++; $display("FAIL idle_busy: busy-high cycles %0d want 0", busy_hi_total - bh); end
    total++; if (obs_cyc.size() - np !== 0) begin bad++; $display("FAIL idle_valid: pulses %0d want 0", obs_cyc.size() - np); end
  endtask

  task automatic test_letter_a();
    exp_cyc.delete(); exp_code.delete(); exp_err.delete();
    ob = obs_cyc.size();
    q = {2, 2, 6, 10};
    play(q);
    total++; if (obs_cyc.size() - ob !== 1) begin bad++; $display("FAIL a_count: got %0d want 1", obs_cyc.size() - ob); end
    if (obs_cyc.size() > ob) begin
      total++;
      if (obs_code[ob] !== 0 || obs_err[ob] !== 0 || obs_cyc[ob] !== exp_cyc[0]) begin
        bad++;
        $display("FAIL a_pulse: got cyc=%0d code=%0d err=%0d want cyc=%0d code=0 err=0",
                 obs_cyc[ob], obs_code[ob], obs_err[ob], exp_cyc[0]);
      end
    end
  endtask

  task automatic test_b_then_e();
    exp_cyc.delete(); exp_code.delete(); exp_err.delete();
    ob = obs_cyc.size();
    q = {6, 2, 2, 2, 2, 2, 2, 6, 2, 10};
    play(q);
    total++; if (obs_cyc.size() - ob !== 2) begin bad++; $display("FAIL be_count: got %0d want 2", obs_cyc.size() - ob); end
    for (int i = 0; i < exp_cyc.size(); i++) begin
      if (ob + i < obs_cyc.size()) begin
        total++;
        if (obs_cyc[ob+i] !== exp_cyc[i] || obs_code[ob+i] !== exp_code[i] || obs_err[ob+i] !== exp_err[i]) begin
          bad++;
          $display("FAIL be_pulse%0d: got cyc=%0d code=%0d err=%0d want cyc=%0d code=%0d err=%0d",
                   i, obs_cyc[ob+i], obs_code[ob+i], obs_err[ob+i], exp_cyc[i], exp_code[i], exp_err[i]);
        end
      end
    end
    if (obs_cyc.size() - ob == 2) begin
      total++; if (obs_idle[ob+1] <= 0) begin bad++; $display("FAIL be_busy_gap: idle cycles %0d want >0", obs_idle[ob+1]); end
    end
  endtask

  task automatic test_thresholds();
    exp_cyc.delete(); exp_code.delete(); exp_err.delete();
    ob = obs_cyc.size();
    // 3-cycle mark, 4-cycle mark, 3-cycle space, 4-cycle space.
    q = {3, 8, 4, 8, 1, 3, 1, 8, 1, 4, 2, 8};
    play(q);
    total++; if (obs_cyc.size() - ob !== 5) begin bad++; $display("FAIL th_count: got %0d want 5", obs_cyc.size() - ob); end
    for (int i = 0; i < exp_cyc.size(); i++) begin
      if (ob + i < obs_cyc.size()) begin
        total++;
        if (obs_cyc[ob+i] !== exp_cyc[i] || obs_code[ob+i] !== exp_code[i] || obs_err[ob+i] !== exp_err[i]) begin
          bad++;
          $display("FAIL th_pulse%0d: got cyc=%0d code=%0d err=%0d want cyc=%0d code=%0d err=%0d",
                   i, obs_cyc[ob+i], obs_code[ob+i], obs_err[ob+i], exp_cyc[i], exp_code[i], exp_err[i]);
        end
      end
    end
  endtask

  task automatic test_unknown_overflow();
    exp_cyc.delete(); exp_code.delete(); exp_err.delete();
    ob = obs_cyc.size();
    // "..--", six dots, then T.
    q = {1, 1, 1, 1, 4, 1, 4, 8,
         1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 8,
         5, 10};
    play(q);
    total++; if (obs_cyc.size() - ob !== 3) begin bad++; $display("FAIL uo_count: got %0d want 3", obs_cyc.size() - ob); end
    for (int i = 0; i < exp_cyc.size(); i++) begin
      if (ob + i < obs_cyc.size()) begin
        total++;
        if (obs_cyc[ob+i] !== exp_cyc[i] || obs_code[ob+i] !== exp_code[i] || obs_err[ob+i] !== exp_err[i]) begin
          bad++;
          $display("FAIL uo_pulse%0d: got cyc=%0d code=%0d err=%0d want cyc=%0d code=%0d err=%0d",
                   i, obs_cyc[ob+i], obs_code[ob+i], obs_err[ob+i], exp_cyc[i], exp_code[i], exp_err[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_letter();
    ob = obs_cyc.size();
    repeat (2) begin @(negedge clk); led = 1'b1; end
    repeat (2) begin @(negedge clk); led = 1'b0; end
    repeat (4) begin @(negedge clk); led = 1'b1; end
    @(negedge clk);
    rst = 1'b0;
    led = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (obs_cyc.size() - ob !== 0) begin bad++; $display("FAIL mid_reset_pulse: pulses %0d want 0", obs_cyc.size() - ob); end
    exp_cyc.delete(); exp_code.delete(); exp_err.delete();
    ob = obs_cyc.size();
    q = {6, 10};
    play(q);
    total++; if (obs_cyc.size() - ob !== 1) begin bad++; $display("FAIL mid_t_count: got %0d want 1", obs_cyc.size() - ob); end
    if (obs_cyc.size() > ob) begin
      total++;
      if (obs_code[ob] !== 19 || obs_err[ob] !== 0 || obs_cyc[ob] !== exp_cyc[0]) begin
        bad++;
        $display("FAIL mid_t_pulse: got cyc=%0d code=%0d err=%0d want cyc=%0d code=19 err=0",
                 obs_cyc[ob], obs_code[ob], obs_err[ob], exp_cyc[0]);
      end
    end
  endtask

  task automatic test_random();
    string s;
    int    pick;
    int    len;
    exp_cyc.delete(); exp_code.delete(); exp_err.delete();
    ob = obs_cyc.size();
    q.delete();
    for (int n = 0; n < 24; n++) begin
      pick = int'($urandom_range(0, 29));
      s = "";
      if (pick < 26) begin
        s = MORSE[pick];
      end else begin
        len = int'($urandom_range(1, 7));
        for (int j = 0; j < len; j++) begin
          if ($urandom_range(0, 1) == 1) s = $sformatf("%s-", s);
          else                           s = $sformatf("%s.", s);
        end
      end
      for (int j = 0; j < s.len(); j++) begin
        if (s[j] == "-") q.push_back(int'($urandom_range(TH, 20)));
        else             q.push_back(int'($urandom_range(1, TH - 1)));
        if (j < s.len() - 1) q.push_back(int'($urandom_range(1, TH - 1)));
        else                 q.push_back(int'($urandom_range(TH + 2, TH + 8)));
      end
    end
    play(q);
    repeat (4) @(negedge clk);
    total++; if (obs_cyc.size() - ob !== exp_cyc.size()) begin bad++; $display("FAIL rnd_count: got %0d want %0d", obs_cyc.size() - ob, exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size(); i++) begin
      if (ob + i < obs_cyc.size()) begin
        total++;
        if (obs_cyc[ob+i] !== exp_cyc[i] || obs_code[ob+i] !== exp_code[i] || obs_err[ob+i] !== exp_err[i]) begin
          bad++;
          $display("FAIL rnd_pulse%0d: got cyc=%0d code=%0d err=%0d want cyc=%0d code=%0d err=%0d",
                   i, obs_cyc[ob+i], obs_code[ob+i], obs_err[ob+i], exp_cyc[i], exp_code[i], exp_err[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_letter_a();
    test_b_then_e();
    test_thresholds();
    test_unknown_overflow();
    test_reset_mid_letter();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
